// File: rtl/regfile_breakable.sv
`default_nettype none
// ============================================================================
// Module      : regfile_breakable
// Description : DEPTH x WIDTH register file, one write port and two
//               combinational read ports. Entry 0 is hardwired to zero.
//               A fault-injection engine latches a configuration on a rising
//               edge of faultactive. While ACTIVE, it corrupts writes to the
//               latched target register:
//                 0 = stuck-at-0
//                 1 = stuck-at-1
//                 2 = dead register
//                 3 = decoder alias to faultaddr^1
//               A saturating counter records every write the fault changed.
// Ports       : clk, reset (sync, active-high)
//               wrenable/wraddr/wrdata           - write port
//               rdaddr1/rddata1, rdaddr2/rddata2 - combinational reads
//               faultactive/faultmode/faultaddr/faultbit - fault request
//               faultstate  - 1 while the fault FSM is ACTIVE
//               faultcount  - saturating corrupted-write count
// Options     : define REGFILE_WRITE_BYPASS_EN to make a same-cycle write
//               (post-fault data) visible on the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_breakable #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int ADDRW = 5,
    parameter int CNTW  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wrenable,
    input  logic [ADDRW-1:0]         wraddr,
    input  logic [WIDTH-1:0]         wrdata,
    input  logic [ADDRW-1:0]         rdaddr1,
    output logic [WIDTH-1:0]         rddata1,
    input  logic [ADDRW-1:0]         rdaddr2,
    output logic [WIDTH-1:0]         rddata2,
    input  logic                     faultactive,
    input  logic [1:0]               faultmode,
    input  logic [ADDRW-1:0]         faultaddr,
    input  logic [$clog2(WIDTH)-1:0] faultbit,
    output logic                     faultstate,
    output logic [CNTW-1:0]          faultcount
);

    localparam int BITW = $clog2(WIDTH);

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_ACTIVE = 1'b1;

    localparam logic [1:0] c_MODE_SA0   = 2'd0;
    localparam logic [1:0] c_MODE_SA1   = 2'd1;
    localparam logic [1:0] c_MODE_DEAD  = 2'd2;
    localparam logic [1:0] c_MODE_ALIAS = 2'd3;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [0:0]       state_q, state_d;
    logic             fa_prev_q, fa_prev_d;
    logic [1:0]       mode_q, mode_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [BITW-1:0]  bit_q, bit_d;
    logic [CNTW-1:0]  count_q, count_d;

    logic             w_arm;
    logic             w_hit;
    logic             w_corrupt;
    logic [ADDRW-1:0] w_alias;
    logic [WIDTH-1:0] w_forced;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;

    // Fault FSM. Configuration is captured only on the arming edge, so
    // holding faultactive high keeps the original configuration.
    always_comb begin
        w_arm     = faultactive & ~fa_prev_q;
        fa_prev_d = faultactive;
        state_d   = state_q;
        mode_d    = mode_q;
        addr_d    = addr_q;
        bit_d     = bit_q;
        case (state_q)
            c_IDLE: begin
                if (w_arm) begin
                    state_d = c_ACTIVE;
                    mode_d  = faultmode;
                    addr_d  = faultaddr;
                    bit_d   = faultbit;
                end
            end
            c_ACTIVE: begin
                if (!faultactive) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // Write path with fault application. The fault acts on the registered
    // state, so a write on the arming edge itself is still clean.
    always_comb begin
        w_alias   = addr_q ^ ADDRW'(1);
        w_hit     = (state_q == c_ACTIVE) && wrenable &&
                    (wraddr == addr_q) && (addr_q != '0);
        w_forced  = wrdata;
        w_forced[bit_q] = (mode_q == c_MODE_SA1);
        w_corrupt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wrenable && (wraddr != '0)) begin
            if (!w_hit) begin
                mem_d[wraddr] = wrdata;
            end else begin
                case (mode_q)
                    c_MODE_SA0, c_MODE_SA1: begin
                        mem_d[wraddr] = w_forced;
                        w_corrupt     = (w_forced != wrdata);
                    end
                    c_MODE_DEAD: begin
                        w_corrupt = 1'b1;
                    end
                    c_MODE_ALIAS: begin
                        mem_d[wraddr] = wrdata;
                        // An alias onto entry 0 is swallowed by the hardwired zero.
                        if (w_alias != '0) begin
                            mem_d[w_alias] = wrdata;
                            w_corrupt      = 1'b1;
                        end
                    end
                    default: mem_d[wraddr] = wrdata;
                endcase
            end
        end
        count_d = count_q;
        if (w_corrupt && (count_q != {CNTW{1'b1}})) begin
            count_d = count_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            state_q   <= c_IDLE;
            fa_prev_q <= 1'b0;
            mode_q    <= '0;
            addr_q    <= '0;
            bit_q     <= '0;
            count_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            state_q   <= state_d;
            fa_prev_q <= fa_prev_d;
            mode_q    <= mode_d;
            addr_q    <= addr_d;
            bit_q     <= bit_d;
            count_q   <= count_d;
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    // Next-state image already carries the post-fault data (and the old value
    // for a dead register), so reading it gives write-through behaviour.
    assign w_rd1 = mem_d[rdaddr1];
    assign w_rd2 = mem_d[rdaddr2];
`else
    assign w_rd1 = mem_q[rdaddr1];
    assign w_rd2 = mem_q[rdaddr2];
`endif

    assign rddata1    = (rdaddr1 == '0) ? '0 : w_rd1;
    assign rddata2    = (rdaddr2 == '0) ? '0 : w_rd2;
    assign faultstate = (state_q == c_ACTIVE);
    assign faultcount = count_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_breakable.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_breakable
// Description : Self-checking bench for regfile_breakable (CNTW = 2 so the
//               counter saturates quickly). Directed vector table, a
//               same-cycle read/write sequence, then randomized traffic
//               against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_breakable;

    localparam int c_WIDTH = 32;
    localparam int c_DEPTH = 32;
    localparam int c_ADDRW = 5;
    localparam int c_CNTW  = 2;
    localparam int c_CMAX  = (1 << c_CNTW) - 1;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1, rd2;
    logic        fa;
    logic [1:0]  fm;
    logic [4:0]  fad;
    logic [4:0]  fb;
    logic        fstate;
    logic [1:0]  fcount;

    int checks = 0;
    int errors = 0;

    regfile_breakable #(
        .WIDTH(c_WIDTH), .DEPTH(c_DEPTH), .ADDRW(c_ADDRW), .CNTW(c_CNTW)
    ) dut (
        .clk(clk), .reset(rst),
        .wrenable(we), .wraddr(wa), .wrdata(wd),
        .rdaddr1(ra1), .rddata1(rd1),
        .rdaddr2(ra2), .rddata2(rd2),
        .faultactive(fa), .faultmode(fm), .faultaddr(fad), .faultbit(fb),
        .faultstate(fstate), .faultcount(fcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: registers as a plain array plus the fault configuration.
    logic [31:0] m_mem [c_DEPTH];
    bit          m_active, m_prev;
    int          m_mode, m_addr, m_bit, m_count;

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        return (a == 0) ? 32'd0 : m_mem[a];
    endfunction

    task automatic model_edge();
        bit          hit;
        bit          inc;
        logic [31:0] nv;
        int          alias_a;
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) m_mem[i] = 32'd0;
            m_active = 0; m_prev = 0; m_mode = 0; m_addr = 0; m_bit = 0; m_count = 0;
            return;
        end
        inc = 0;
        hit = m_active && we && (int'(wa) == m_addr) && (m_addr != 0);
        if (we && wa != 0) begin
            if (!hit) begin
                m_mem[wa] = wd;
            end else begin
                case (m_mode)
                    0: begin
                        nv = wd & ~(32'd1 << m_bit);
                        inc = (nv != wd);
                        m_mem[wa] = nv;
                    end
                    1: begin
                        nv = wd | (32'd1 << m_bit);
                        inc = (nv != wd);
                        m_mem[wa] = nv;
                    end
                    2: inc = 1;
                    default: begin
                        m_mem[wa] = wd;
                        alias_a = m_addr ^ 1;
                        if (alias_a != 0) begin
                            m_mem[alias_a] = wd;
                            inc = 1;
                        end
                    end
                endcase
            end
        end
        if (inc && m_count < c_CMAX) m_count++;
        if (!m_active && fa && !m_prev) begin
            m_active = 1;
            m_mode = int'(fm); m_addr = int'(fad); m_bit = int'(fb);
        end else if (m_active && !fa) begin
            m_active = 0;
        end
        m_prev = fa;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock edge; strobes are dropped afterwards so reads show stored state.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        we  = 1'b0;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rst, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1, ra2;
        logic        fa;
        logic [1:0]  fm;
        logic [4:0]  fad, fb;
        logic [31:0] e1, e2;
        logic        est;
        logic [1:0]  ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, input logic w, input logic [4:0] a, input logic [31:0] d,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic f, input logic [1:0] m, input logic [4:0] fa_, input logic [4:0] b,
        input logic [31:0] x1, input logic [31:0] x2, input logic xs, input logic [1:0] xc);
        vec_t v;
        v.rst = r; v.we = w; v.wa = a; v.wd = d; v.ra1 = r1; v.ra2 = r2;
        v.fa = f; v.fm = m; v.fad = fa_; v.fb = b;
        v.e1 = x1; v.e2 = x2; v.est = xs; v.ecnt = xc;
        return v;
    endfunction

    initial begin
        rst = 0; we = 0; wa = 0; wd = 0; ra1 = 0; ra2 = 0;
        fa = 0; fm = 0; fad = 0; fb = 0;
        for (int i = 0; i < c_DEPTH; i++) m_mem[i] = 32'd0;
        m_active = 0; m_prev = 0; m_mode = 0; m_addr = 0; m_bit = 0; m_count = 0;

        // rst we wa wd  ra1 ra2  fa fm fad fb  exp_rd1 exp_rd2 exp_state exp_count
        vecs.push_back(mk(1,0,0,32'h0,        5,0, 0,0,0,0, 32'h0,        32'h0,        0,0));
        vecs.push_back(mk(0,1,5,32'hDEADBEEF, 5,0, 0,0,0,0, 32'hDEADBEEF, 32'h0,        0,0));
        vecs.push_back(mk(0,1,0,32'h1234,     5,0, 0,0,0,0, 32'hDEADBEEF, 32'h0,        0,0));
        vecs.push_back(mk(0,0,0,32'h0,        7,5, 1,0,7,0, 32'h0,        32'hDEADBEEF, 1,0));
        vecs.push_back(mk(0,1,7,32'hF,        7,5, 1,2,3,5, 32'hE,        32'hDEADBEEF, 1,1));
        vecs.push_back(mk(0,1,7,32'h2,        7,5, 1,2,3,5, 32'h2,        32'hDEADBEEF, 1,1));
        vecs.push_back(mk(0,0,0,32'h0,        7,5, 0,0,0,0, 32'h2,        32'hDEADBEEF, 0,1));
        vecs.push_back(mk(0,1,3,32'h55,       3,7, 0,0,0,0, 32'h55,       32'h2,        0,1));
        vecs.push_back(mk(0,0,0,32'h0,        3,7, 1,2,3,0, 32'h55,       32'h2,        1,1));
        vecs.push_back(mk(0,1,3,32'hAA,       3,7, 1,2,3,0, 32'h55,       32'h2,        1,2));
        vecs.push_back(mk(0,0,0,32'h0,        3,7, 0,0,0,0, 32'h55,       32'h2,        0,2));
        vecs.push_back(mk(0,1,3,32'hAA,       3,7, 0,0,0,0, 32'hAA,       32'h2,        0,2));
        vecs.push_back(mk(0,0,0,32'h0,        1,0, 1,3,1,0, 32'h0,        32'h0,        1,2));
        vecs.push_back(mk(0,1,1,32'h77,       1,0, 1,3,1,0, 32'h77,       32'h0,        1,2));
        vecs.push_back(mk(0,0,0,32'h0,        1,0, 0,0,0,0, 32'h77,       32'h0,        0,2));
        vecs.push_back(mk(0,0,0,32'h0,        4,5, 1,3,4,0, 32'h0,        32'hDEADBEEF, 1,2));
        vecs.push_back(mk(0,1,4,32'h99,       4,5, 1,3,4,0, 32'h99,       32'h99,       1,3));
        vecs.push_back(mk(0,0,0,32'h0,        4,5, 0,0,0,0, 32'h99,       32'h99,       0,3));
        vecs.push_back(mk(0,0,0,32'h0,        6,3, 1,2,6,0, 32'h0,        32'hAA,       1,3));
        vecs.push_back(mk(1,1,6,32'h11,       5,3, 1,2,6,0, 32'h0,        32'h0,        0,0));
        vecs.push_back(mk(0,0,0,32'h0,        6,4, 1,2,6,0, 32'h0,        32'h0,        1,0));
        for (int k = 0; k < 5; k++) begin
            vecs.push_back(mk(0,1,6,32'h100 + 32'(k), 6,4, 1,2,6,0, 32'h0, 32'h0, 1,
                              (k + 1 > c_CMAX) ? 2'(c_CMAX) : 2'(k + 1)));
        end
        vecs.push_back(mk(1,0,0,32'h0,        7,9, 0,0,0,0, 32'h0,        32'h0,        0,0));
        vecs.push_back(mk(0,0,0,32'h0,        5,3, 0,0,0,0, 32'h0,        32'h0,        0,0));

        #2;
        foreach (vecs[i]) begin
            rst = vecs[i].rst; we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
            ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
            fa = vecs[i].fa; fm = vecs[i].fm; fad = vecs[i].fad; fb = vecs[i].fb;
            tick();
            check($sformatf("vec%0d rd1", i), rd1, vecs[i].e1);
            check($sformatf("vec%0d rd2", i), rd2, vecs[i].e2);
            check($sformatf("vec%0d state", i), 32'(fstate), 32'(vecs[i].est));
            check($sformatf("vec%0d count", i), 32'(fcount), 32'(vecs[i].ecnt));
        end

        // Same-cycle read of a register being written.
        fa = 0; we = 1; wa = 9; wd = 32'h11; ra1 = 9; ra2 = 0;
        tick();
        check("r9 first write", rd1, 32'h11);
        we = 1; wa = 9; wd = 32'h42; ra1 = 9;
        #2;
`ifdef REGFILE_WRITE_BYPASS_EN
        check("same-cycle read", rd1, 32'h42);
`else
        check("same-cycle read", rd1, 32'h11);
`endif
        tick();
        check("read after write", rd1, 32'h42);

        // Randomized traffic against the reference model.
        rst = 1;
        tick();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            we  = ($urandom_range(0, 3) != 0);
            wa  = 5'($urandom_range(0, 7));
            wd  = $urandom;
            ra1 = 5'($urandom_range(0, 7));
            ra2 = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) fa = ~fa;
            fm  = 2'($urandom_range(0, 3));
            fad = 5'($urandom_range(0, 7));
            fb  = 5'($urandom_range(0, 31));
            tick();
            check($sformatf("rand%0d rd1", n), rd1, m_rd(ra1));
            check($sformatf("rand%0d rd2", n), rd2, m_rd(ra2));
            check($sformatf("rand%0d state", n), 32'(fstate), 32'(m_active));
            check($sformatf("rand%0d count", n), 32'(fcount), 32'(m_count));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
